// File: rtl/fm_sb_pkg.sv
// -----------------------------------------------------------------------------
// fm_sb_pkg
// Shared definitions for the fast-monitoring spy buffer freeze control:
// the per-buffer capture state encoding and the default counter width.
// -----------------------------------------------------------------------------
package fm_sb_pkg;

    // Default width of the post-trigger depth and the write/post counters.
    localparam int unsigned FM_SB_CNT_W = 16;

    // Per-buffer capture state; encodings are visible on state_o.
    typedef enum logic [1:0] {
        FM_SB_IDLE   = 2'b00,
        FM_SB_ARMED  = 2'b01,
        FM_SB_POST   = 2'b10,
        FM_SB_FROZEN = 2'b11
    } fm_sb_frz_state_t;

endpackage : fm_sb_pkg

// File: rtl/fm_sb_freeze_fsm.sv
// -----------------------------------------------------------------------------
// fm_sb_freeze_fsm
// Capture sequencer for a single spy buffer: arm -> trigger -> post-trigger
// word count -> freeze -> release.
//
// Ports:
//   clk_hs        in   monitored-data clock
//   rst_hs        in   synchronous active-high reset
//   arm_i         in   single-cycle arm strobe
//   trig_i        in   single-cycle trigger (already combined sw/ext)
//   release_i     in   single-cycle release/abort strobe, highest priority
//   wr_vld_i      in   spy buffer write enable
//   post_depth_i  in   post-trigger word count, latched at trigger
//   freeze_o      out  freeze to the spy buffer (state == FROZEN)
//   state_o       out  raw state register
//   trig_pos_o    out  write count latched at trigger
// -----------------------------------------------------------------------------
module fm_sb_freeze_fsm
    import fm_sb_pkg::*;
#(
    parameter int unsigned CNT_W = FM_SB_CNT_W
) (
    input  logic             clk_hs,
    input  logic             rst_hs,
    input  logic             arm_i,
    input  logic             trig_i,
    input  logic             release_i,
    input  logic             wr_vld_i,
    input  logic [CNT_W-1:0] post_depth_i,
    output logic             freeze_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] trig_pos_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    fm_sb_frz_state_t state_q;
    logic [CNT_W-1:0] wr_cnt_q;
    logic [CNT_W-1:0] post_cnt_q;
    logic [CNT_W-1:0] depth_q;
    logic [CNT_W-1:0] trig_pos_q;

    always_ff @(posedge clk_hs) begin
        if (rst_hs) begin
            state_q    <= FM_SB_IDLE;
            wr_cnt_q   <= '0;
            post_cnt_q <= '0;
            depth_q    <= '0;
            trig_pos_q <= '0;
        end else if (release_i) begin
            state_q <= FM_SB_IDLE;
        end else begin
            unique case (state_q)
                FM_SB_IDLE: begin
                    // Arm wins over a coincident trigger: the trigger is dropped.
                    if (arm_i) begin
                        state_q  <= FM_SB_ARMED;
                        wr_cnt_q <= '0;
                    end
                end
                FM_SB_ARMED: begin
                    if (wr_vld_i && (wr_cnt_q != '1)) begin
                        wr_cnt_q <= wr_cnt_q + ONE;
                    end
                    if (trig_i) begin
                        // Position is the count before this cycle's write.
                        trig_pos_q <= wr_cnt_q;
                        depth_q    <= post_depth_i;
                        post_cnt_q <= '0;
                        state_q    <= (post_depth_i == '0) ? FM_SB_FROZEN : FM_SB_POST;
                    end
                end
                FM_SB_POST: begin
                    if (wr_vld_i) begin
                        post_cnt_q <= post_cnt_q + ONE;
                        if (post_cnt_q == (depth_q - ONE)) begin
                            state_q <= FM_SB_FROZEN;
                        end
                    end
                end
                FM_SB_FROZEN: begin
                    state_q <= FM_SB_FROZEN;
                end
                default: begin
                    state_q <= FM_SB_IDLE;
                end
            endcase
        end
    end

    // Freeze is a pure decode of the state register, so it rises in the
    // first cycle after the completing edge without an extra flop.
    assign freeze_o   = (state_q == FM_SB_FROZEN);
    assign state_o    = state_q;
    assign trig_pos_o = trig_pos_q;

endmodule : fm_sb_freeze_fsm

// File: rtl/fm_sb_freeze_ctrl.sv
// -----------------------------------------------------------------------------
// fm_sb_freeze_ctrl
// Freeze sequencer for TOTAL_SB spy buffers; one independent capture FSM per
// buffer. Gates the shared external trigger per buffer and packs outputs.
//
// Ports:
//   clk_hs         in   monitored-data clock (only clock)
//   rst_hs         in   synchronous active-high reset
//   arm_i          in   [TOTAL_SB]        per-buffer arm strobe
//   sw_trig_i      in   [TOTAL_SB]        per-buffer software trigger
//   ext_trig_i     in   1                 shared external trigger
//   ext_trig_en_i  in   [TOTAL_SB]        per-buffer external trigger enable
//   release_i      in   [TOTAL_SB]        per-buffer release/abort strobe
//   post_depth_i   in   [CNT_W]           post-trigger depth, shared
//   wr_vld_i       in   [TOTAL_SB]        per-buffer write enable
//   freeze_o       out  [TOTAL_SB]        freeze to the spy buffers
//   state_o        out  [2*TOTAL_SB]      buffer i at [2i+1:2i]
//   trig_pos_o     out  [CNT_W*TOTAL_SB]  buffer i at [CNT_W*(i+1)-1:CNT_W*i]
// -----------------------------------------------------------------------------
module fm_sb_freeze_ctrl
    import fm_sb_pkg::*;
#(
    parameter int unsigned TOTAL_SB = 2,
    parameter int unsigned CNT_W    = FM_SB_CNT_W
) (
    input  logic                      clk_hs,
    input  logic                      rst_hs,
    input  logic [TOTAL_SB-1:0]       arm_i,
    input  logic [TOTAL_SB-1:0]       sw_trig_i,
    input  logic                      ext_trig_i,
    input  logic [TOTAL_SB-1:0]       ext_trig_en_i,
    input  logic [TOTAL_SB-1:0]       release_i,
    input  logic [CNT_W-1:0]          post_depth_i,
    input  logic [TOTAL_SB-1:0]       wr_vld_i,
    output logic [TOTAL_SB-1:0]       freeze_o,
    output logic [2*TOTAL_SB-1:0]     state_o,
    output logic [CNT_W*TOTAL_SB-1:0] trig_pos_o
);

    logic [TOTAL_SB-1:0] trig;

    assign trig = sw_trig_i | ({TOTAL_SB{ext_trig_i}} & ext_trig_en_i);

    for (genvar i = 0; i < int'(TOTAL_SB); i++) begin : g_sb
        fm_sb_freeze_fsm #(
            .CNT_W (CNT_W)
        ) u_fsm (
            .clk_hs       (clk_hs),
            .rst_hs       (rst_hs),
            .arm_i        (arm_i[i]),
            .trig_i       (trig[i]),
            .release_i    (release_i[i]),
            .wr_vld_i     (wr_vld_i[i]),
            .post_depth_i (post_depth_i),
            .freeze_o     (freeze_o[i]),
            .state_o      (state_o[2*i +: 2]),
            .trig_pos_o   (trig_pos_o[CNT_W*i +: CNT_W])
        );
    end

endmodule : fm_sb_freeze_ctrl

// File: tb/tb_fm_sb_freeze_ctrl.sv
module tb_fm_sb_freeze_ctrl;

    localparam int NSB = 2;

    logic clk_hs = 1'b0;
    always #5 clk_hs = ~clk_hs;

    logic              rst_hs;
    logic [NSB-1:0]    arm, sw, ext_en, rel, vld;
    logic              ext;
    logic [15:0]       pdepth;

    logic [NSB-1:0]    frz16, frz4;
    logic [2*NSB-1:0]  st16, st4;
    logic [16*NSB-1:0] tp16;
    logic [4*NSB-1:0]  tp4;

    // Full-width instance and a narrow instance to exercise saturation.
    fm_sb_freeze_ctrl #(.TOTAL_SB(NSB), .CNT_W(16)) dut (
        .clk_hs(clk_hs), .rst_hs(rst_hs), .arm_i(arm), .sw_trig_i(sw),
        .ext_trig_i(ext), .ext_trig_en_i(ext_en), .release_i(rel),
        .post_depth_i(pdepth), .wr_vld_i(vld),
        .freeze_o(frz16), .state_o(st16), .trig_pos_o(tp16));

    fm_sb_freeze_ctrl #(.TOTAL_SB(NSB), .CNT_W(4)) dut4 (
        .clk_hs(clk_hs), .rst_hs(rst_hs), .arm_i(arm), .sw_trig_i(sw),
        .ext_trig_i(ext), .ext_trig_en_i(ext_en), .release_i(rel),
        .post_depth_i(pdepth[3:0]), .wr_vld_i(vld),
        .freeze_o(frz4), .state_o(st4), .trig_pos_o(tp4));

    typedef struct {
        logic [1:0]  frz;
        logic [3:0]  st;
        logic [31:0] tp;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];

    int n_pass = 0;
    int n_tot  = 0;
    bit done   = 0;

    // Reference model: per instance k (0 = 16-bit, 1 = 4-bit), per buffer i.
    // phase: 0 idle, 1 armed, 2 collecting post-trigger words, 3 frozen.
    int ph   [2][NSB];
    int wr   [2][NSB];
    int rem  [2][NSB];
    int tpos [2][NSB];

    task automatic model_edge();
        int sat, dep;
        bit trig;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            sat = (k == 0) ? 65535 : 15;
            dep = (k == 0) ? int'(pdepth) : int'(pdepth) % 16;
            for (int i = 0; i < NSB; i++) begin
                trig = sw[i] | (ext & ext_en[i]);
                if (rst_hs) begin
                    ph[k][i] = 0; wr[k][i] = 0; rem[k][i] = 0; tpos[k][i] = 0;
                end else if (rel[i]) begin
                    ph[k][i] = 0;
                end else if (ph[k][i] == 0) begin
                    if (arm[i]) begin ph[k][i] = 1; wr[k][i] = 0; end
                end else if (ph[k][i] == 1) begin
                    if (trig) begin
                        tpos[k][i] = wr[k][i];
                        rem[k][i]  = dep;
                        ph[k][i]   = (dep == 0) ? 3 : 2;
                    end else if (vld[i]) begin
                        wr[k][i] = (wr[k][i] + 1 > sat) ? sat : wr[k][i] + 1;
                    end
                end else if (ph[k][i] == 2) begin
                    if (vld[i]) begin
                        rem[k][i] = rem[k][i] - 1;
                        if (rem[k][i] == 0) ph[k][i] = 3;
                    end
                end
            end
            e.frz = '0; e.st = '0; e.tp = '0;
            for (int i = 0; i < NSB; i++) begin
                e.frz[i] = (ph[k][i] == 3);
                e.st[2*i +: 2] = 2'(ph[k][i]);
                if (k == 0) e.tp[16*i +: 16] = 16'(tpos[k][i]);
                else        e.tp[4*i +: 4]   = 4'(tpos[k][i]);
            end
            if (k == 0) q16.push_back(e);
            else        q4.push_back(e);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    // Monitor: DUT outputs are presented every cycle; compare 1 ns after the edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk_hs);
            #1;
            if (q16.size() > 0) begin
                e = q16.pop_front();
                chk("freeze16", 32'(frz16), 32'(e.frz));
                chk("state16",  32'(st16),  32'(e.st));
                chk("trigpos16", tp16, e.tp);
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                chk("freeze4", 32'(frz4), 32'(e.frz));
                chk("state4",  32'(st4),  32'(e.st));
                chk("trigpos4", 32'(tp4), e.tp);
            end
        end
    end

    // One clock: inputs already set; model the edge, then clear strobes.
    task automatic tick();
        @(posedge clk_hs);
        model_edge();
        @(negedge clk_hs);
        rst_hs = 0; arm = '0; sw = '0; ext = 0; rel = '0; vld = '0;
    endtask

    initial begin
        rst_hs = 1; arm = '0; sw = '0; ext = 0; ext_en = '0; rel = '0; vld = '0;
        pdepth = '0;
        @(negedge clk_hs);
        rst_hs = 1; tick();
        rst_hs = 1; tick();

        // Reset in the middle of a post-trigger window.
        pdepth = 16'd8; arm = 2'b01; tick();
        sw = 2'b01; tick();
        repeat (3) begin vld = 2'b01; tick(); end
        rst_hs = 1; tick();
        tick();

        // Basic capture with gaps between post-trigger words.
        arm = 2'b01; tick();
        repeat (5) begin vld = 2'b01; tick(); end
        pdepth = 16'd4; sw = 2'b01; vld = 2'b01; tick();
        repeat (4) begin vld = 2'b01; tick(); tick(); end
        tick();
        rel = 2'b01; tick();

        // Depth zero with external trigger enabled only for buffer 0.
        pdepth = 16'd0; ext_en = 2'b01; arm = 2'b11; tick();
        ext = 1; tick();
        tick();
        rel = 2'b11; tick();
        ext_en = 2'b00;

        // Priority cases.
        arm = 2'b01; tick();
        rel = 2'b01; sw = 2'b01; tick();
        arm = 2'b01; sw = 2'b01; tick();
        vld = 2'b01; tick();
        sw = 2'b01; tick();
        sw = 2'b01; arm = 2'b01; tick();
        rel = 2'b01; tick();
        rel = 2'b01; tick();

        // Depth changed during the post-trigger window.
        pdepth = 16'd3; arm = 2'b10; tick();
        sw = 2'b10; tick();
        pdepth = 16'd10;
        repeat (3) begin vld = 2'b10; tick(); end
        tick();
        rel = 2'b10; tick();
        tick();

        // Saturation of the narrow write counter.
        arm = 2'b11; tick();
        repeat (20) begin vld = 2'b11; tick(); end
        pdepth = 16'd2; sw = 2'b11; tick();
        repeat (2) begin vld = 2'b11; tick(); end
        tick();
        rel = 2'b11; tick();

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            rst_hs = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NSB; i++) begin
                arm[i] = ($urandom_range(0, 7) == 0);
                sw[i]  = ($urandom_range(0, 39) == 0);
                rel[i] = ($urandom_range(0, 59) == 0);
                vld[i] = ($urandom_range(0, 1) == 0);
            end
            ext = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) == 0) ext_en = 2'($urandom);
            if ($urandom_range(0, 9) == 0)  pdepth = 16'($urandom_range(0, 12));
            tick();
        end

        repeat (3) @(posedge clk_hs);
        done = 1;
        #2;
        chk("queue16_drained", 32'(q16.size()), 32'd0);
        chk("queue4_drained",  32'(q4.size()),  32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule : tb_fm_sb_freeze_ctrl
